// File: rtl/lc2k_pkg.sv
// Shared types and encodings for the LC2K multi-cycle controller.
package lc2k_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_NOR  = 3'd1,
        OP_LW   = 3'd2,
        OP_SW   = 3'd3,
        OP_BEQ  = 3'd4,
        OP_JALR = 3'd5,
        OP_HALT = 3'd6,
        OP_NOOP = 3'd7
    } opcode_t;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_NOR   = 2'b01;
    localparam logic [1:0] ALU_EQUAL = 2'b10;

    localparam logic [1:0] PC_INC    = 2'b00;
    localparam logic [1:0] PC_OFFSET = 2'b01;
    localparam logic [1:0] PC_REGA   = 2'b10;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC  = 2'b10;

    localparam logic ADDR_PC   = 1'b0;
    localparam logic ADDR_ALU  = 1'b1;
    localparam logic SRCB_REG  = 1'b0;
    localparam logic SRCB_IMM  = 1'b1;
    localparam logic DST_RD    = 1'b0;
    localparam logic DST_RB    = 1'b1;

    function automatic state_t exec_next(opcode_t op);
        case (op)
            OP_ADD, OP_NOR: return ST_WB;
            OP_LW, OP_SW:   return ST_MEM;
            OP_HALT:        return ST_HALT;
            default:        return ST_FETCH;
        endcase
    endfunction

endpackage

// File: rtl/lc2k_if.sv
// Control bus between the LC2K controller and its datapath/memory.
interface lc2k_if;
    logic [31:0] instr;
    logic        mem_ack;
    logic        alu_beq;
    logic        mem_req;
    logic        mem_we;
    logic        mem_addr_sel;
    logic        ir_we;
    logic [1:0]  alu_op;
    logic        alu_srcb_sel;
    logic        rf_we;
    logic        rf_dst_sel;
    logic [1:0]  rf_wdata_sel;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic        halted;

    modport master (
        input  instr, mem_ack, alu_beq,
        output mem_req, mem_we, mem_addr_sel, ir_we, alu_op, alu_srcb_sel,
               rf_we, rf_dst_sel, rf_wdata_sel, pc_we, pc_sel, halted
    );

    modport slave (
        output instr, mem_ack, alu_beq,
        input  mem_req, mem_we, mem_addr_sel, ir_we, alu_op, alu_srcb_sel,
               rf_we, rf_dst_sel, rf_wdata_sel, pc_we, pc_sel, halted
    );
endinterface

// File: rtl/lc2k_ctrl_decode.sv
// Combinational strobe decode from FSM state, latched opcode, mem_ack and alu_beq.
module lc2k_ctrl_decode
    import lc2k_pkg::*;
(
    input  state_t      state,
    input  opcode_t     opcode,
    input  logic        active,
    input  logic        mem_ack,
    input  logic        alu_beq,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_we,
    output logic [1:0]  alu_op,
    output logic        alu_srcb_sel,
    output logic        rf_we,
    output logic        rf_dst_sel,
    output logic [1:0]  rf_wdata_sel,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        halted
);

    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = ADDR_PC;
        ir_we        = 1'b0;
        alu_op       = ALU_ADD;
        alu_srcb_sel = SRCB_REG;
        rf_we        = 1'b0;
        rf_dst_sel   = DST_RD;
        rf_wdata_sel = WB_ALU;
        pc_we        = 1'b0;
        pc_sel       = PC_INC;
        halted       = 1'b0;

        // The cycle right after reset stays silent even though state is FETCH.
        if (active) begin
            case (state)
                ST_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ack) begin
                        ir_we  = 1'b1;
                        pc_we  = 1'b1;
                        pc_sel = PC_INC;
                    end
                end
                ST_EXEC: begin
                    case (opcode)
                        OP_NOR:       alu_op = ALU_NOR;
                        OP_LW, OP_SW: alu_srcb_sel = SRCB_IMM;
                        OP_BEQ: begin
                            alu_op = ALU_EQUAL;
                            if (alu_beq) begin
                                pc_we  = 1'b1;
                                pc_sel = PC_OFFSET;
                            end
                        end
                        OP_JALR: begin
                            rf_we        = 1'b1;
                            rf_dst_sel   = DST_RB;
                            rf_wdata_sel = WB_PC;
                            pc_we        = 1'b1;
                            pc_sel       = PC_REGA;
                        end
                        default: ;
                    endcase
                end
                ST_MEM: begin
                    mem_req      = 1'b1;
                    mem_addr_sel = ADDR_ALU;
                    mem_we       = (opcode == OP_SW);
                end
                ST_WB: begin
                    rf_we = 1'b1;
                    if (opcode == OP_LW) begin
                        rf_dst_sel   = DST_RB;
                        rf_wdata_sel = WB_MEM;
                    end
                end
                ST_HALT: halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/lc2k_control.sv
// LC2K multi-cycle control FSM; LC2K_INSTR_COUNT_EN adds a retired-instruction counter.
//  state     | meaning
//  ST_FETCH  | read instruction at PC, wait for mem_ack
//  ST_DECODE | one idle cycle for register read
//  ST_EXEC   | ALU op; beq/jalr/noop/halt finish here
//  ST_MEM    | lw/sw data access, wait for mem_ack
//  ST_WB     | register-file write for add/nor/lw
//  ST_HALT   | stopped until reset
module lc2k_control
    import lc2k_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    lc2k_if.master      bus
`ifdef LC2K_INSTR_COUNT_EN
    ,
    output logic [31:0] retired
`endif
);

    state_t  state, state_nxt;
    opcode_t opcode;
    logic    active;
    logic    fetch_ack;
    logic    unused_instr;

    assign unused_instr = ^{bus.instr[31:25], bus.instr[21:0]};
    assign fetch_ack    = active && (state == ST_FETCH) && bus.mem_ack;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_FETCH;
            opcode <= OP_ADD;
            active <= 1'b0;
        end else begin
            state  <= state_nxt;
            active <= 1'b1;
            if (fetch_ack) opcode <= opcode_t'(bus.instr[24:22]);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_FETCH:  if (fetch_ack) state_nxt = ST_DECODE;
            ST_DECODE: state_nxt = ST_EXEC;
            ST_EXEC:   state_nxt = exec_next(opcode);
            ST_MEM:    if (bus.mem_ack) state_nxt = (opcode == OP_LW) ? ST_WB : ST_FETCH;
            ST_WB:     state_nxt = ST_FETCH;
            ST_HALT:   state_nxt = ST_HALT;
            default:   state_nxt = ST_FETCH;
        endcase
    end

    lc2k_ctrl_decode u_decode (
        .state        (state),
        .opcode       (opcode),
        .active       (active),
        .mem_ack      (bus.mem_ack),
        .alu_beq      (bus.alu_beq),
        .mem_req      (bus.mem_req),
        .mem_we       (bus.mem_we),
        .mem_addr_sel (bus.mem_addr_sel),
        .ir_we        (bus.ir_we),
        .alu_op       (bus.alu_op),
        .alu_srcb_sel (bus.alu_srcb_sel),
        .rf_we        (bus.rf_we),
        .rf_dst_sel   (bus.rf_dst_sel),
        .rf_wdata_sel (bus.rf_wdata_sel),
        .pc_we        (bus.pc_we),
        .pc_sel       (bus.pc_sel),
        .halted       (bus.halted)
    );

`ifdef LC2K_INSTR_COUNT_EN
    logic retire;

    // Final cycle of an instruction: leaving for FETCH from any non-FETCH state, or entering HALT.
    assign retire = ((state != ST_FETCH) && (state != ST_HALT) && (state_nxt == ST_FETCH)) ||
                    ((state == ST_EXEC) && (state_nxt == ST_HALT));

    always_ff @(posedge clk) begin
        if (reset)       retired <= '0;
        else if (retire) retired <= retired + 32'd1;
    end
`endif

endmodule

// File: tb/tb_lc2k_control.sv
// Self-checking bench: per-instruction expected cycle sequences built from the ISA timing rules.
module tb_lc2k_control;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    lc2k_if bus();

`ifdef LC2K_INSTR_COUNT_EN
    logic [31:0] retired;
`endif

    lc2k_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef LC2K_INSTR_COUNT_EN
        ,
        .retired (retired)
`endif
    );

    typedef struct {
        logic        ack;
        logic        beq;
        logic [31:0] instr;
        logic [14:0] exp;
        int unsigned ret;
    } cyc_t;

    cyc_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail = 0;
    int unsigned model_ret = 0;

    logic [14:0] obs;
    assign obs = {bus.mem_req, bus.mem_we, bus.mem_addr_sel, bus.ir_we, bus.alu_op,
                  bus.alu_srcb_sel, bus.rf_we, bus.rf_dst_sel, bus.rf_wdata_sel,
                  bus.pc_we, bus.pc_sel, bus.halted};

    function automatic logic [14:0] outs(input logic req, input logic we, input logic asel,
                                         input logic irwe, input logic [1:0] aop, input logic srcb,
                                         input logic rfwe, input logic dst, input logic [1:0] wsel,
                                         input logic pcwe, input logic [1:0] psel, input logic hlt);
        return {req, we, asel, irwe, aop, srcb, rfwe, dst, wsel, pcwe, psel, hlt};
    endfunction

    function automatic logic rb();
        return $urandom_range(0, 1) == 1;
    endfunction

    function automatic logic [31:0] rnd_instr(input logic [2:0] op);
        logic [31:0] w;
        w = $urandom;
        w[24:22] = op;
        return w;
    endfunction

    task automatic push(input logic ack, input logic beq, input logic [31:0] instr,
                        input logic [14:0] exp);
        cyc_t c;
        c.ack = ack; c.beq = beq; c.instr = instr; c.exp = exp; c.ret = model_ret;
        exp_q.push_back(c);
    endtask

    // One instruction: fw fetch wait cycles, mw data wait cycles, bt = beq outcome.
    task automatic build(input logic [2:0] op, input int fw, input int mw, input logic bt);
        logic [14:0] e;
        for (int i = 0; i < fw; i++)
            push(1'b0, rb(), $urandom, outs(1,0,0,0,2'b00,0,0,0,2'b00,0,2'b00,0));
        push(1'b1, rb(), rnd_instr(op), outs(1,0,0,1,2'b00,0,0,0,2'b00,1,2'b00,0));
        push(rb(), rb(), $urandom, 15'd0);
        case (op)
            3'd1:       e = outs(0,0,0,0,2'b01,0,0,0,2'b00,0,2'b00,0);
            3'd2, 3'd3: e = outs(0,0,0,0,2'b00,1,0,0,2'b00,0,2'b00,0);
            3'd4:       e = outs(0,0,0,0,2'b10,0,0,0,2'b00,bt,bt ? 2'b01 : 2'b00,0);
            3'd5:       e = outs(0,0,0,0,2'b00,0,1,1,2'b10,1,2'b10,0);
            default:    e = 15'd0;
        endcase
        push(rb(), (op == 3'd4) ? bt : rb(), $urandom, e);
        if (op >= 3'd4) model_ret++;
        if (op == 3'd2 || op == 3'd3) begin
            e = outs(1, op == 3'd3, 1, 0, 2'b00, 0, 0, 0, 2'b00, 0, 2'b00, 0);
            for (int i = 0; i < mw; i++) push(1'b0, rb(), $urandom, e);
            push(1'b1, rb(), $urandom, e);
            if (op == 3'd3) model_ret++;
        end
        if (op <= 3'd2) begin
            push(rb(), rb(), $urandom,
                 outs(0,0,0,0,2'b00,0,1,op == 3'd2,(op == 3'd2) ? 2'b01 : 2'b00,0,2'b00,0));
            model_ret++;
        end
    endtask

    task automatic apply(input cyc_t c);
        @(negedge clk);
        bus.mem_ack = c.ack;
        bus.alu_beq = c.beq;
        bus.instr   = c.instr;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; bus.mem_ack = 1'b1; bus.alu_beq = 1'b1; bus.instr = $urandom;
        @(negedge clk); #1;
        n_tests++;
        if (obs !== 15'd0) begin
            n_fail++; $display("FAIL reset_outputs got=%b want=%b", obs, 15'd0);
        end
`ifdef LC2K_INSTR_COUNT_EN
        n_tests++;
        if (retired !== 32'd0) begin
            n_fail++; $display("FAIL reset_retired got=%0d want=0", retired);
        end
`endif
        reset = 1'b0;
        model_ret = 0;
    endtask

    task automatic test_add_nor();
        cyc_t c;
        int k = 0;
        build(3'd0, 0, 0, 1'b0);
        build(3'd1, 1, 0, 1'b0);
        while (exp_q.size() > 0) begin
            c = exp_q.pop_front(); apply(c); n_tests++;
            if (obs !== c.exp) begin n_fail++; $display("FAIL add_nor cyc%0d got=%b want=%b", k, obs, c.exp); end
`ifdef LC2K_INSTR_COUNT_EN
            n_tests++;
            if (retired !== c.ret) begin n_fail++; $display("FAIL add_nor_ret cyc%0d got=%0d want=%0d", k, retired, c.ret); end
`endif
            k++;
        end
    endtask

    task automatic test_lw_wait();
        cyc_t c;
        int k = 0;
        build(3'd2, 0, 3, 1'b0);
        build(3'd2, 2, 0, 1'b0);
        while (exp_q.size() > 0) begin
            c = exp_q.pop_front(); apply(c); n_tests++;
            if (obs !== c.exp) begin n_fail++; $display("FAIL lw_wait cyc%0d got=%b want=%b", k, obs, c.exp); end
`ifdef LC2K_INSTR_COUNT_EN
            n_tests++;
            if (retired !== c.ret) begin n_fail++; $display("FAIL lw_wait_ret cyc%0d got=%0d want=%0d", k, retired, c.ret); end
`endif
            k++;
        end
    endtask

    task automatic test_beq();
        cyc_t c;
        int k = 0;
        build(3'd4, 0, 0, 1'b1);
        build(3'd4, 2, 0, 1'b0);
        while (exp_q.size() > 0) begin
            c = exp_q.pop_front(); apply(c); n_tests++;
            if (obs !== c.exp) begin n_fail++; $display("FAIL beq cyc%0d got=%b want=%b", k, obs, c.exp); end
            k++;
        end
    endtask

    task automatic test_jalr_noop();
        cyc_t c;
        int k = 0;
        build(3'd5, 0, 0, 1'b0);
        build(3'd7, 1, 0, 1'b0);
        build(3'd3, 0, 2, 1'b0);
        while (exp_q.size() > 0) begin
            c = exp_q.pop_front(); apply(c); n_tests++;
            if (obs !== c.exp) begin n_fail++; $display("FAIL jalr_noop_sw cyc%0d got=%b want=%b", k, obs, c.exp); end
`ifdef LC2K_INSTR_COUNT_EN
            n_tests++;
            if (retired !== c.ret) begin n_fail++; $display("FAIL jalr_ret cyc%0d got=%0d want=%0d", k, retired, c.ret); end
`endif
            k++;
        end
    endtask

    task automatic test_random_program();
        cyc_t c;
        int k = 0;
        logic [2:0] op;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 6));
            if (op == 3'd6) op = 3'd7;
            build(op, $urandom_range(0, 2), $urandom_range(0, 2), rb());
        end
        while (exp_q.size() > 0) begin
            c = exp_q.pop_front(); apply(c); n_tests++;
            if (obs !== c.exp) begin n_fail++; $display("FAIL random cyc%0d got=%b want=%b", k, obs, c.exp); end
`ifdef LC2K_INSTR_COUNT_EN
            n_tests++;
            if (retired !== c.ret) begin n_fail++; $display("FAIL random_ret cyc%0d got=%0d want=%0d", k, retired, c.ret); end
`endif
            k++;
        end
    endtask

    task automatic test_sw_abort();
        cyc_t c;
        int k = 0;
        build(3'd3, 0, 6, 1'b0);
        for (int i = 0; i < 5; i++) begin
            c = exp_q.pop_front(); apply(c); n_tests++;
            if (obs !== c.exp) begin n_fail++; $display("FAIL sw_abort cyc%0d got=%b want=%b", k, obs, c.exp); end
            k++;
        end
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1; bus.mem_ack = 1'b1;
        #1;
        n_tests++;
        if (obs !== outs(1,1,1,0,2'b00,0,0,0,2'b00,0,2'b00,0)) begin
            n_fail++; $display("FAIL sw_abort_hold got=%b want=mem write", obs);
        end
        @(negedge clk); #1;
        n_tests++;
        if (bus.mem_req !== 1'b0 || obs !== 15'd0) begin
            n_fail++; $display("FAIL sw_abort_drop got=%b want=%b", obs, 15'd0);
        end
`ifdef LC2K_INSTR_COUNT_EN
        n_tests++;
        if (retired !== 32'd0) begin n_fail++; $display("FAIL sw_abort_ret got=%0d want=0", retired); end
`endif
        reset = 1'b0; bus.mem_ack = 1'b0;
        model_ret = 0;
    endtask

    task automatic test_halt_reset();
        cyc_t c;
        int k = 0;
        build(3'd0, 0, 0, 1'b0);
        build(3'd6, 1, 0, 1'b0);
        for (int i = 0; i < 10; i++)
            push(rb(), rb(), $urandom, outs(0,0,0,0,2'b00,0,0,0,2'b00,0,2'b00,1));
        while (exp_q.size() > 0) begin
            c = exp_q.pop_front(); apply(c); n_tests++;
            if (obs !== c.exp) begin n_fail++; $display("FAIL halt cyc%0d got=%b want=%b", k, obs, c.exp); end
`ifdef LC2K_INSTR_COUNT_EN
            n_tests++;
            if (retired !== c.ret) begin n_fail++; $display("FAIL halt_ret cyc%0d got=%0d want=%0d", k, retired, c.ret); end
`endif
            k++;
        end
        @(negedge clk);
        reset = 1'b1; bus.mem_ack = 1'b1;
        @(negedge clk); #1;
        n_tests++;
        if (obs !== 15'd0) begin n_fail++; $display("FAIL halt_reset got=%b want=%b", obs, 15'd0); end
        reset = 1'b0; bus.mem_ack = 1'b0;
        model_ret = 0;
        @(negedge clk); #1;
        n_tests++;
        if (obs !== outs(1,0,0,0,2'b00,0,0,0,2'b00,0,2'b00,0)) begin
            n_fail++; $display("FAIL fetch_after_reset got=%b want=fetch request", obs);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "timeout");
    end

    initial begin
        bus.mem_ack = 1'b0;
        bus.alu_beq = 1'b0;
        bus.instr   = 32'd0;
        test_reset();
        test_add_nor();
        test_lw_wait();
        test_beq();
        test_jalr_noop();
        test_random_program();
        test_sw_abort();
        test_random_program();
        test_halt_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lc2k_control.md
LC2K_CONTROL -- requirements
Module: lc2k_control

Interface
REQ-001 clk  in  1  sole clock; all state changes on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 instr  in  32  instruction word from memory; sampled only on mem_ack in FETCH.
REQ-004 mem_ack  in  1  memory completion; a read returns data in the same cycle.
REQ-005 alu_beq  in  1  ALU equality flag; sampled only in EXEC of beq.
REQ-006 mem_req  out  1  memory access request; held until mem_ack.
REQ-007 mem_we  out  1  write strobe, valid with mem_req.
REQ-008 mem_addr_sel  out  1  0=PC, 1=ALU result.
REQ-009 ir_we  out  1  instruction-register load.
REQ-010 alu_op  out  2  00=ADD, 01=NOR, 10=EQUAL; 11 is never driven.
REQ-011 alu_srcb_sel  out  1  0=regB, 1=sign-extended offset[15:0].
REQ-012 rf_we  out  1  register-file write enable.
REQ-013 rf_dst_sel  out  1  0=instr[2:0], 1=instr[18:16].
REQ-014 rf_wdata_sel  out  2  00=ALU, 01=memory data, 10=PC; 11 is never driven.
REQ-015 pc_we  out  1  PC load.
REQ-016 pc_sel  out  2  00=PC+1, 01=PC+offset, 10=regA; 11 is never driven.
REQ-017 halted  out  1  high while in HALT.

Function
REQ-018 States SHALL be FETCH, DECODE, EXEC, MEM, WB and HALT; output strobes are decoded from state, the latched opcode, mem_ack and alu_beq.
REQ-019 FETCH: mem_req=1 and mem_addr_sel=0 each cycle until mem_ack; on ack, assert ir_we and pc_we (pc_sel=00), latch instr[24:22] as opcode, and go to DECODE.
REQ-020 DECODE: no strobes asserted; go to EXEC.
REQ-021 EXEC add/nor: alu_op=00/01, alu_srcb_sel=0; go to WB.
REQ-022 EXEC lw/sw: alu_op=00, alu_srcb_sel=1; go to MEM.
REQ-023 MEM: mem_req=1, mem_addr_sel=1, mem_we=1 for sw only, held until mem_ack; on ack, lw goes to WB and sw goes to FETCH.
REQ-024 WB: rf_we=1 for one cycle; add/nor use rf_dst_sel=0 and rf_wdata_sel=00; lw uses rf_dst_sel=1 and rf_wdata_sel=01; go to FETCH.
REQ-025 EXEC beq: alu_op=10, alu_srcb_sel=0; if alu_beq=1, pc_we=1 with pc_sel=01 (PC already incremented); go to FETCH.
REQ-026 EXEC jalr: rf_we=1, rf_dst_sel=1, rf_wdata_sel=10 and pc_we=1 with pc_sel=10 in the same cycle; when regA==regB the register file writes the old PC+1 and the PC loads the pre-write regA value; go to FETCH.
REQ-027 EXEC noop: go to FETCH; EXEC halt: go to HALT.
REQ-028 HALT: all strobes 0 and halted=1 until reset.
REQ-029 Latency with zero-wait memory: add/nor/sw take 4 cycles, lw 5 cycles, beq/jalr/noop 3 cycles; each memory wait cycle adds 1.
REQ-030 Every 3-bit opcode is defined; no illegal-opcode state exists.

Reset
REQ-031 With reset high at a clock edge, state SHALL become FETCH, the latched opcode 000, and all outputs 0 in the following cycle.
REQ-032 Reset mid-FETCH or mid-MEM SHALL drop mem_req without waiting for mem_ack; a mem_ack arriving with reset high is ignored.
REQ-033 Reset SHALL take priority over every transition, including leaving HALT.

Configuration
REQ-034 With LC2K_INSTR_COUNT_EN defined, the block SHALL add an output retired (32 bits): reset to 0, incremented once per instruction on its final cycle (halt counts on entry to HALT), wrapping 0xFFFFFFFF->0.
REQ-035 Without LC2K_INSTR_COUNT_EN, neither the port nor the counter exists; all other behaviour is identical.

Structure
REQ-036 Package lc2k_pkg SHALL hold the opcode enum, ALU-op constants (ADD/NOR/EQUAL), state enum, and the PC/writeback/address select constants.
REQ-037 Output decode SHALL be a combinational sub-module, lc2k_ctrl_decode; the FSM register and next-state logic stay in lc2k_control.

Verification
REQ-038 add, zero-wait ack -> ir_we+pc_we in cycle 1, alu_op=00 in cycle 3, rf_we with rf_dst_sel=0 in cycle 4, FETCH in cycle 5.
REQ-039 lw, 3-cycle data wait in MEM -> mem_req held 3 cycles with mem_addr_sel=1 and mem_we=0, then WB with rf_wdata_sel=01 and rf_dst_sel=1; total 8 cycles.
REQ-040 beq with alu_beq=1, then with alu_beq=0 -> pc_we=1 with pc_sel=01 in EXEC; no pc_we in EXEC.
REQ-041 jalr -> single EXEC cycle with rf_we=1, rf_wdata_sel=10, pc_we=1, pc_sel=10.
REQ-042 halt, then 10 idle cycles, then reset -> halted=1 and no strobes while halted; FETCH with mem_req=1 one cycle after reset is released.
REQ-043 reset asserted during a sw MEM wait -> mem_req=0 next cycle; with the macro on, retired is unchanged by the aborted sw and reads 0.
